// File: rtl/note_key_encoder_pkg.sv
// Shared note constants, FSM state type and sharp-legality helper for the
// note key encoder and the display logic that consumes its outputs.
package notas_pkg;

  localparam logic [2:0] NOTA_DO    = 3'd0;
  localparam logic [2:0] NOTA_RE    = 3'd1;
  localparam logic [2:0] NOTA_MI    = 3'd2;
  localparam logic [2:0] NOTA_FA    = 3'd3;
  localparam logic [2:0] NOTA_SOL   = 3'd4;
  localparam logic [2:0] NOTA_LA    = 3'd5;
  localparam logic [2:0] NOTA_SI    = 3'd6;
  localparam logic [2:0] NOTA_PAUSA = 3'd7;

  typedef enum logic [0:0] {
    OCIOSO  = 1'b0,
    TOCANDO = 1'b1
  } estado_t;

  // Mi and Si have no sharp on the keyboard; a rest has no sharp either.
  function automatic logic nota_tem_sustenido(input logic [2:0] nota);
    logic tem;
    case (nota)
      NOTA_MI:    tem = 1'b0;
      NOTA_SI:    tem = 1'b0;
      NOTA_PAUSA: tem = 1'b0;
      default:    tem = 1'b1;
    endcase
    return tem;
  endfunction

endpackage

// File: rtl/note_key_encoder_if.sv
// Key/switch inputs and latched note outputs of the note key encoder.
// master = key scanner side (drives keys), slave = the encoder itself.
interface note_key_encoder_if;

  logic [6:0] TECLAS;
  logic       TOM_SW;
  logic [2:0] NOTAS;
  logic       TOM_OUT;
  logic       ATIVO;
  logic       VALIDO;

  modport master (
    output TECLAS,
    output TOM_SW,
    input  NOTAS,
    input  TOM_OUT,
    input  ATIVO,
    input  VALIDO
  );

  modport slave (
    input  TECLAS,
    input  TOM_SW,
    output NOTAS,
    output TOM_OUT,
    output ATIVO,
    output VALIDO
  );

endinterface

// File: rtl/note_key_encoder_debounce_bit.sv
// One raw input: 2-flop synchroniser followed by a stability counter.
// The debounced value only flips after the synced value has disagreed with
// it on DEBOUNCE_CYCLES consecutive edges; any agreement restarts the count.
module debounce_bit #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             sync1_r;
  logic             sync2_r;
  logic             deb_r;
  logic [CNT_W-1:0] cnt_r;

  // Bring the asynchronous key level into the clock domain.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= din;
      sync2_r <= sync1_r;
    end
  end

  // Count consecutive disagreements; accept the new level on the last one.
  always_ff @(posedge clk) begin
    if (rst) begin
      deb_r <= 1'b0;
      cnt_r <= CNT_ZERO;
    end else if (sync2_r != deb_r) begin
      if (cnt_r == CNT_LAST) begin
        deb_r <= sync2_r;
        cnt_r <= CNT_ZERO;
      end else begin
        cnt_r <= cnt_r + CNT_ONE;
      end
    end else begin
      cnt_r <= CNT_ZERO;
    end
  end

  assign dout = deb_r;

endmodule

// File: rtl/note_key_encoder.sv
// Note key encoder: debounces seven note keys plus the sharp switch, picks
// the lowest pressed key, latches it (sticky while held) and strobes VALIDO
// whenever the latched note code or sharp flag changes.
module note_key_encoder
  import notas_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic              CLK,
  input  logic              RESET,
  note_key_encoder_if.slave io
);

  logic [7:0] raw_s;
  logic [7:0] deb_s;
  logic [6:0] keys_s;
  logic       tom_s;
  logic [7:0] key_ext_s;
  logic       any_key_s;
  logic [2:0] prio_s;
  logic       prio_tom_s;
  logic       held_key_s;
  logic       held_tom_s;

  estado_t    estado_r;
  estado_t    estado_nxt_s;
  logic [2:0] nota_r;
  logic [2:0] nota_nxt_s;
  logic       tom_r;
  logic       tom_nxt_s;
  logic       ativo_r;
  logic       ativo_nxt_s;
  logic       valido_r;
  logic       valido_nxt_s;

  assign raw_s = {io.TOM_SW, io.TECLAS};

  for (genvar g = 0; g < 8; g++) begin : g_deb
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk (CLK),
      .rst (RESET),
      .din (raw_s[g]),
      .dout(deb_s[g])
    );
  end

  assign keys_s    = deb_s[6:0];
  assign tom_s     = deb_s[7];
  assign key_ext_s = {1'b0, keys_s};
  assign any_key_s = |keys_s;

  // Lowest-index pressed key wins; no key gives the rest code.
  always_comb begin
    prio_s = NOTA_PAUSA;
    casez (keys_s)
      7'b??????1: prio_s = NOTA_DO;
      7'b?????10: prio_s = NOTA_RE;
      7'b????100: prio_s = NOTA_MI;
      7'b???1000: prio_s = NOTA_FA;
      7'b??10000: prio_s = NOTA_SOL;
      7'b?100000: prio_s = NOTA_LA;
      7'b1000000: prio_s = NOTA_SI;
      default:    prio_s = NOTA_PAUSA;
    endcase
  end

  // Effective sharp for a candidate new note and for the currently held one.
  always_comb begin
    prio_tom_s = tom_s & nota_tem_sustenido(prio_s);
    held_tom_s = tom_s & nota_tem_sustenido(nota_r);
    held_key_s = key_ext_s[nota_r];
  end

  // Next-state and next-output logic; VALIDO is raised only on a real change.
  always_comb begin
    estado_nxt_s = estado_r;
    nota_nxt_s   = nota_r;
    tom_nxt_s    = tom_r;
    ativo_nxt_s  = ativo_r;
    valido_nxt_s = 1'b0;
    case (estado_r)
      OCIOSO: begin
        if (any_key_s) begin
          nota_nxt_s   = prio_s;
          tom_nxt_s    = prio_tom_s;
          ativo_nxt_s  = 1'b1;
          valido_nxt_s = 1'b1;
          estado_nxt_s = TOCANDO;
        end else begin
          nota_nxt_s   = NOTA_PAUSA;
          tom_nxt_s    = 1'b0;
          ativo_nxt_s  = 1'b0;
        end
      end
      TOCANDO: begin
        if (held_key_s) begin
          if (held_tom_s != tom_r) begin
            tom_nxt_s    = held_tom_s;
            valido_nxt_s = 1'b1;
          end else begin
            tom_nxt_s    = tom_r;
          end
        end else if (any_key_s) begin
          nota_nxt_s   = prio_s;
          tom_nxt_s    = prio_tom_s;
          valido_nxt_s = 1'b1;
        end else begin
          nota_nxt_s   = NOTA_PAUSA;
          tom_nxt_s    = 1'b0;
          ativo_nxt_s  = 1'b0;
          valido_nxt_s = 1'b1;
          estado_nxt_s = OCIOSO;
        end
      end
      default: begin
        nota_nxt_s   = NOTA_PAUSA;
        tom_nxt_s    = 1'b0;
        ativo_nxt_s  = 1'b0;
        estado_nxt_s = OCIOSO;
      end
    endcase
  end

  // State and output registers; reset returns to rest with no strobe.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      estado_r <= OCIOSO;
      nota_r   <= NOTA_PAUSA;
      tom_r    <= 1'b0;
      ativo_r  <= 1'b0;
      valido_r <= 1'b0;
    end else begin
      estado_r <= estado_nxt_s;
      nota_r   <= nota_nxt_s;
      tom_r    <= tom_nxt_s;
      ativo_r  <= ativo_nxt_s;
      valido_r <= valido_nxt_s;
    end
  end

  assign io.NOTAS   = nota_r;
  assign io.TOM_OUT = tom_r;
  assign io.ATIVO   = ativo_r;
  assign io.VALIDO  = valido_r;

endmodule

// File: tb/tb_note_key_encoder.sv
// Bench for note_key_encoder: directed scenarios plus randomized key/switch
// activity, all checked against a history-window reference model.
module tb_note_key_encoder;

  localparam int D = 4;

  logic CLK   = 1'b0;
  logic RESET = 1'b1;

  note_key_encoder_if bus_if();

  note_key_encoder #(
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .CLK  (CLK),
    .RESET(RESET),
    .io   (bus_if.slave)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: a key's debounced level flips when the last D synced
  // samples (raw delayed by two edges) all disagree with it.
  logic [7:0] hist [0:D+1];
  logic [7:0] m_deb;
  int         m_held;
  logic       m_tom;
  logic       m_valido;
  int         m_low;
  logic       m_nt;
  logic       m_all;

  function automatic int lowest_key(input logic [6:0] k);
    for (int i = 0; i < 7; i++) begin
      if (k[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic tom_allowed(input int n, input logic t);
    return t && (n != 2) && (n != 6);
  endfunction

  always @(posedge CLK) begin
    if (RESET) begin
      m_deb    = 8'd0;
      for (int i = 0; i < D + 2; i++) hist[i] = 8'd0;
      m_held   = -1;
      m_tom    = 1'b0;
      m_valido = 1'b0;
    end else begin
      m_low    = lowest_key(m_deb[6:0]);
      m_valido = 1'b0;
      if (m_held < 0) begin
        if (m_low >= 0) begin
          m_held   = m_low;
          m_tom    = tom_allowed(m_low, m_deb[7]);
          m_valido = 1'b1;
        end
      end else if (m_deb[m_held]) begin
        m_nt = tom_allowed(m_held, m_deb[7]);
        if (m_nt != m_tom) begin
          m_tom    = m_nt;
          m_valido = 1'b1;
        end
      end else begin
        if (m_low >= 0) begin
          m_held = m_low;
          m_tom  = tom_allowed(m_low, m_deb[7]);
        end else begin
          m_held = -1;
          m_tom  = 1'b0;
        end
        m_valido = 1'b1;
      end
      for (int i = 0; i < D + 1; i++) hist[i] = hist[i+1];
      hist[D+1] = {bus_if.TOM_SW, bus_if.TECLAS};
      for (int b = 0; b < 8; b++) begin
        m_all = 1'b1;
        for (int i = 0; i < D; i++) begin
          if (hist[i][b] == m_deb[b]) m_all = 1'b0;
        end
        if (m_all) m_deb[b] = ~m_deb[b];
      end
    end
  end

  // Continuous comparison of every output against the model.
  always @(negedge CLK) begin
    if (chk_en) begin
      check_value("m_notas", 32'(bus_if.NOTAS), 32'((m_held < 0) ? 7 : m_held));
      check_value("m_tom", 32'(bus_if.TOM_OUT), 32'(m_tom));
      check_value("m_ativo", 32'(bus_if.ATIVO), 32'((m_held >= 0) ? 1 : 0));
      check_value("m_valido", 32'(bus_if.VALIDO), 32'(m_valido));
    end
  end

  task automatic drive(input logic [6:0] k, input logic t);
    bus_if.TECLAS = k;
    bus_if.TOM_SW = t;
  endtask

  task automatic wait_valido(input string tag, output int cycles);
    cycles = 0;
    do begin
      @(negedge CLK);
      cycles++;
    end while (bus_if.VALIDO !== 1'b1 && cycles < 40);
    if (bus_if.VALIDO !== 1'b1) check_value({tag, "_timeout"}, 32'(bus_if.VALIDO), 32'(1));
  endtask

  task automatic count_valido(input int n, output int pulses);
    pulses = 0;
    repeat (n) begin
      @(negedge CLK);
      if (bus_if.VALIDO === 1'b1) pulses++;
    end
  endtask

  task automatic check_out(input string tag, input int notas, input int tom, input int ativo);
    check_value({tag, "_notas"}, 32'(bus_if.NOTAS), 32'(notas));
    check_value({tag, "_tom"}, 32'(bus_if.TOM_OUT), 32'(tom));
    check_value({tag, "_ativo"}, 32'(bus_if.ATIVO), 32'(ativo));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "bench did not finish");
  end

  int         cyc;
  int         pul;
  int         hold;
  logic [6:0] rk;

  initial begin
    drive(7'd0, 1'b0);
    repeat (3) @(negedge CLK);
    RESET  = 1'b0;
    chk_en = 1'b1;
    check_out("rst", 7, 0, 0);
    check_value("rst_valido", 32'(bus_if.VALIDO), 32'(0));

    // Re press: strobe 7 cycles after first sample
    drive(7'b0000010, 1'b0);
    wait_valido("re", cyc);
    check_value("re_latency", 32'(cyc), 32'(7));
    check_out("re", 1, 0, 1);
    @(negedge CLK);
    check_value("re_pulse_width", 32'(bus_if.VALIDO), 32'(0));
    drive(7'd0, 1'b0);
    wait_valido("re_rel", cyc);
    count_valido(6, pul);

    // 3-cycle glitch on Fa is rejected
    drive(7'b0001000, 1'b0);
    repeat (3) @(negedge CLK);
    drive(7'd0, 1'b0);
    count_valido(15, pul);
    check_value("fa_glitch_pulses", 32'(pul), 32'(0));
    check_out("fa_glitch", 7, 0, 0);

    // Sol with sharp, Do added (sticky), then Sol released
    drive(7'b0010000, 1'b1);
    wait_valido("sol", cyc);
    check_out("sol", 4, 1, 1);
    drive(7'b0010001, 1'b1);
    count_valido(12, pul);
    check_value("sol_sticky_pulses", 32'(pul), 32'(0));
    check_out("sol_sticky", 4, 1, 1);
    drive(7'b0000001, 1'b1);
    wait_valido("do", cyc);
    check_out("do", 0, 1, 1);

    // Mi never sharp, La sharp
    drive(7'd0, 1'b1);
    wait_valido("do_rel", cyc);
    check_out("do_rel", 7, 0, 0);
    drive(7'b0000100, 1'b1);
    wait_valido("mi", cyc);
    check_out("mi", 2, 0, 1);
    drive(7'b0100000, 1'b1);
    wait_valido("la", cyc);
    check_out("la", 5, 1, 1);

    // La held, sharp toggled off then on, then release everything
    drive(7'b0100000, 1'b0);
    wait_valido("la_tom_off", cyc);
    check_out("la_tom_off", 5, 0, 1);
    drive(7'b0100000, 1'b1);
    wait_valido("la_tom_on", cyc);
    check_out("la_tom_on", 5, 1, 1);
    count_valido(12, pul);
    check_value("la_tom_single", 32'(pul), 32'(0));
    drive(7'd0, 1'b0);
    wait_valido("all_rel", cyc);
    check_out("all_rel", 7, 0, 0);

    // Si held across a reset pulse
    drive(7'b1000000, 1'b0);
    wait_valido("si", cyc);
    check_out("si", 6, 0, 1);
    @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    check_out("si_rst", 7, 0, 0);
    check_value("si_rst_valido", 32'(bus_if.VALIDO), 32'(0));
    wait_valido("si_again", cyc);
    check_value("si_again_latency", 32'(cyc), 32'(7));
    check_out("si_again", 6, 0, 1);

    // Randomized activity, checked by the model on every cycle
    repeat (300) begin
      rk = 7'd0;
      if ($urandom_range(0, 3) != 0) begin
        rk[$urandom_range(0, 6)] = 1'b1;
        if ($urandom_range(0, 2) == 0) rk[$urandom_range(0, 6)] = 1'b1;
      end
      drive(rk, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 60) == 0) begin
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
      end
      hold = $urandom_range(1, 10);
      repeat (hold) @(negedge CLK);
    end

    drive(7'd0, 1'b0);
    repeat (20) @(negedge CLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/note_key_encoder.md
Name: note_key_encoder

Overview:
- Input side of the note display path: scans seven note keys (Do..Si) and a sharp switch, and produces the 3-bit note code NOTAS and the sharp flag TOM. These are the signals the 7-segment note display module consumes.
- Adds synchronisation, per-key debounce, lowest-key priority, note latching, and a one-cycle "new note" strobe for downstream sound/display logic.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive stable cycles required before a key or switch change is accepted (board builds use 50000)
CNT_W, $clog2(DEBOUNCE_CYCLES+1), debounce counter width (derived, not overridden)

Ports:
CLK  input  1  system clock
RESET  input  1  synchronous active-high reset
TECLAS  input  7  raw note keys, active-high; bit0=Do, 1=Re, 2=Mi, 3=Fa, 4=Sol, 5=La, 6=Si
TOM_SW  input  1  raw sharp switch, active-high
NOTAS  output  3  latched note code 0..6; 7 = rest (no note)
TOM_OUT  output  1  sharp flag for the latched note
ATIVO  output  1  high while a note is latched
VALIDO  output  1  one-cycle pulse when NOTAS/TOM_OUT take a new value

Behaviour:
- Interface (decided): one clock, CLK; RESET is synchronous and active-high. All state updates on the CLK rising edge, with RESET having priority.
- Reset values: NOTAS=7, TOM_OUT=0, ATIVO=0, VALIDO=0. Synchronisers, debounced states and counters are cleared. FSM goes to OCIOSO.
- Synchroniser: each of the 8 raw inputs passes through a 2-flop synchroniser.
- Debounce, per input:
  - Counter increments on each edge where the synced value differs from the debounced value.
  - Counter clears on any edge where the two are equal.
  - When the counter equals DEBOUNCE_CYCLES-1 and the values still differ, the debounced value flips and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES cycles is never accepted.
- Latency: a raw change first sampled at edge 1, held stable, updates the debounced value at edge DEBOUNCE_CYCLES+2. The FSM output registers update at edge DEBOUNCE_CYCLES+3, with VALIDO high for exactly the cycle after that edge.
- Priority: when several debounced keys are high, the lowest index wins.
- Sharp legality: the effective TOM is debounced TOM_SW AND NOT (note==2 or note==6). There is no Mi#/Si#, so TOM_OUT is forced to 0 for those notes.
- FSM states: OCIOSO, TOCANDO.
  - OCIOSO, any debounced key high: latch the priority code and effective TOM, set ATIVO=1, pulse VALIDO, go to TOCANDO.
  - OCIOSO, no key: hold NOTAS=7, ATIVO=0.
  - TOCANDO, latched key still high: no change, even if a lower-index key is also pressed. The held note is sticky.
  - TOCANDO, effective TOM changes: update TOM_OUT and pulse VALIDO; NOTAS unchanged.
  - TOCANDO, latched key released and another key high: latch the new priority code and TOM, pulse VALIDO, stay in TOCANDO.
  - TOCANDO, latched key released and no key high: NOTAS=7, TOM_OUT=0, ATIVO=0, pulse VALIDO, go to OCIOSO.
- Simultaneous release of the latched key and a TOM change: only one VALIDO pulse, carrying the new values.
- VALIDO never stays high for two consecutive cycles unless two distinct updates occur on consecutive edges.
- RESET mid-note: all outputs return to reset values on that edge, with no VALIDO pulse. A key still held after RESET falls is re-debounced from zero.

Decomposition:
- Shared package notas_pkg holds:
  - constants NOTA_DO..NOTA_SI = 0..6 and NOTA_PAUSA = 7;
  - FSM state typedef {OCIOSO, TOCANDO};
  - function nota_tem_sustenido(note), which returns 0 for Mi and Si.
- One sub-module, debounce_bit: 2-flop synchroniser plus counter, parameterised by DEBOUNCE_CYCLES. It is instantiated 8 times (7 keys + TOM_SW).
- The top level holds the priority encoder and the FSM.

Test Plan (DEBOUNCE_CYCLES=4):
- After RESET, press Re (TECLAS=7'b0000010) and hold → VALIDO pulses exactly 7 cycles after the first sample; NOTAS=1, TOM_OUT=0, ATIVO=1.
- Key glitch of 3 cycles on Fa → no VALIDO; NOTAS stays 7 and ATIVO stays 0.
- Hold Sol with TOM_SW=1, then press Do as well → NOTAS=4, TOM_OUT=1, and there is no second VALIDO (held note is sticky). Then release Sol → VALIDO, NOTAS=0, TOM_OUT=1.
- Hold Mi with TOM_SW=1 → NOTAS=2, TOM_OUT=0. Switch to La with TOM_SW=1 → NOTAS=5, TOM_OUT=1.
- Hold La, toggle TOM_SW 0→1 → single VALIDO; NOTAS=5, TOM_OUT=1. Then release all → VALIDO, NOTAS=7, TOM_OUT=0, ATIVO=0.
- Hold Si, assert RESET for 1 cycle → next cycle outputs are 7/0/0/0 with no VALIDO. With Si still held, VALIDO reappears 7 cycles after RESET falls, with NOTAS=6.
